sr_latch_driver: RTL



---
 rtl/sr_latch_driver_if.sv | 31 +++
 rtl/sr_latch_driver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver_if.sv
// Command/status channel between a clocked controller and sr_latch_driver.
// The controller owns the request; the driver owns ready, busy and the per-command result.
interface sr_latch_driver_if;
  logic       req_valid;
  logic [1:0] req_op;
  logic       req_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic       q_last;

  modport master (
    output req_valid,
    output req_op,
    input  req_ready,
    input  busy,
    input  done,
    input  err,
    input  q_last
  );

  modport slave (
    input  req_valid,
    input  req_op,
    output req_ready,
    output busy,
    output done,
    output err,
    output q_last
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Drives an unclocked SR latch through a setup/pulse/hold sequence and verifies
// the latch state through a 2-flop synchronizer, reporting done/err per command.
module sr_latch_driver #(
  parameter int SETUP_CYC   = 1,
  parameter int PULSE_CYC   = 2,
  parameter int HOLD_CYC    = 1,
  parameter int ACK_TIMEOUT = 8,
  parameter int CNT_W       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  sr_latch_driver_if.slave    cmd,
  output logic                s,
  output logic                r,
  output logic                en,
  output logic                lrst,
  input  logic                q_fb,
  input  logic                qbar_fb
);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_FORCE = 2'b11;

  // Counter holds "cycles remaining minus one" so a phase of N cycles loads N-1.
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CHECK_LOAD = CNT_W'(ACK_TIMEOUT - 1);

  generate
    if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1 || ACK_TIMEOUT < 1 ||
        (1 << CNT_W) < SETUP_CYC || (1 << CNT_W) < PULSE_CYC ||
        (1 << CNT_W) < HOLD_CYC  || (1 << CNT_W) < ACK_TIMEOUT) begin : g_bad_param
      $error("sr_latch_driver: invalid timing parameters for CNT_W");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       op_reg, op_next;

  logic s_reg, s_next;
  logic r_reg, r_next;
  logic en_reg, en_next;
  logic lrst_reg, lrst_next;
  logic ready_reg, ready_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;
  logic err_reg, err_next;
  logic q_last_reg, q_last_next;

  // Bit 0 carries q, bit 1 carries qbar.
  logic [1:0] fb_raw;
  logic [1:0] sync1_reg, sync2_reg;
  logic       q_sync, qbar_sync;
  logic       exp_q;
  logic       fb_match;
  logic       accept;
  logic       driving;

  assign fb_raw    = {qbar_fb, q_fb};
  assign q_sync    = sync2_reg[0];
  assign qbar_sync = sync2_reg[1];
  assign exp_q     = (op_reg == OP_SET);
  assign fb_match  = (q_sync == exp_q) && (qbar_sync == ~exp_q);
  assign accept    = cmd.req_valid && ready_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 2'b00;
      sync2_reg <= 2'b00;
    end else begin
      sync1_reg <= fb_raw;
      sync2_reg <= sync1_reg;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    op_next     = op_reg;
    done_next   = 1'b0;
    err_next    = err_reg;
    q_last_next = q_last_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          op_next = cmd.req_op;
          if (cmd.req_op == OP_NOP) begin
            state_next  = ST_DONE;
            done_next   = 1'b1;
            err_next    = 1'b0;
            q_last_next = q_sync;
          end else begin
            state_next = ST_SETUP;
            cnt_next   = SETUP_LOAD;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_reg == '0) begin
          state_next = ST_PULSE;
          cnt_next   = PULSE_LOAD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_reg == '0) begin
          state_next = ST_HOLD;
          cnt_next   = HOLD_LOAD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_reg == '0) begin
          state_next = ST_CHECK;
          cnt_next   = CHECK_LOAD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_CHECK: begin
        if (fb_match) begin
          state_next  = ST_DONE;
          done_next   = 1'b1;
          err_next    = 1'b0;
          q_last_next = q_sync;
        end else if (cnt_reg == '0) begin
          state_next  = ST_DONE;
          done_next   = 1'b1;
          err_next    = 1'b1;
          q_last_next = q_sync;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Pin values are decoded from the next state so every output is a plain register.
  always_comb begin
    driving    = (state_next == ST_SETUP) || (state_next == ST_PULSE) ||
                 (state_next == ST_HOLD);
    s_next     = driving && (op_next == OP_SET);
    r_next     = driving && (op_next == OP_CLEAR);
    en_next    = (state_next == ST_PULSE) &&
                 ((op_next == OP_SET) || (op_next == OP_CLEAR));
    lrst_next  = (state_next == ST_PULSE) && (op_next == OP_FORCE);
    ready_next = (state_next == ST_IDLE);
    busy_next  = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      op_reg     <= OP_NOP;
      s_reg      <= 1'b0;
      r_reg      <= 1'b0;
      en_reg     <= 1'b0;
      lrst_reg   <= 1'b0;
      ready_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      q_last_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      op_reg     <= op_next;
      s_reg      <= s_next;
      r_reg      <= r_next;
      en_reg     <= en_next;
      lrst_reg   <= lrst_next;
      ready_reg  <= ready_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      q_last_reg <= q_last_next;
    end
  end

  assign s             = s_reg;
  assign r             = r_reg;
  assign en            = en_reg;
  assign lrst          = lrst_reg;
  assign cmd.req_ready = ready_reg;
  assign cmd.busy      = busy_reg;
  assign cmd.done      = done_reg;
  assign cmd.err       = err_reg;
  assign cmd.q_last    = q_last_reg;

endmodule
